// File: rtl/pair_reorder_in_buffer.sv
// Ping-pong input buffer for the 32-point FFT: serial natural-order samples in, butterfly pairs (x[k], x[k+16]) out.
// Optional: define PAIR_REORDER_BITREV_IN_EN to accept a bit-reversed input stream.
module pair_reorder_in_buffer #(
  parameter int unsigned WORD_LEN = 11
) (
  input  logic                clk,
  input  logic                i_rst,
  input  logic [WORD_LEN-1:0] in_data,
  input  logic                in_valid,
  output logic [WORD_LEN-1:0] out_up,
  output logic [WORD_LEN-1:0] out_down,
  output logic                out_valid,
  output logic                out_last
);

  typedef enum logic {IDLE, OUT} state_t;

  state_t              state_q;
  logic [4:0]          wr_cnt_q, wr_cnt_d;
  logic [4:0]          wr_addr;
  logic                in_bank_q, in_bank_d;
  logic                rd_bank_q;
  logic [3:0]          rd_cnt_q;
  logic                out_valid_q;
  logic                frame_done;
  logic [WORD_LEN-1:0] bank_q [2][32];

`ifdef PAIR_REORDER_BITREV_IN_EN
  always_comb begin
    wr_addr = '0;
    for (int unsigned i = 0; i < 5; i++) begin
      wr_addr[i] = wr_cnt_q[4-i];
    end
  end
`else
  always_comb wr_addr = wr_cnt_q;
`endif

  always_comb begin
    frame_done = in_valid & (wr_cnt_q == 5'd31);
    wr_cnt_d   = wr_cnt_q;
    in_bank_d  = in_bank_q;
    if (in_valid) begin
      wr_cnt_d = wr_cnt_q + 5'd1;
    end
    if (frame_done) begin
      in_bank_d = ~in_bank_q;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      wr_cnt_q    <= '0;
      in_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      rd_cnt_q    <= '0;
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      for (int unsigned b = 0; b < 2; b++) begin
        for (int unsigned w = 0; w < 32; w++) begin
          bank_q[b[0]][w[4:0]] <= '0;
        end
      end
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      in_bank_q <= in_bank_d;
      if (in_valid) begin
        bank_q[in_bank_q][wr_addr] <= in_data;
      end
      // Reading the just-filled bank cannot collide with refilling it: 16 read cycles vs >= 32 fill cycles.
      case (state_q)
        IDLE: begin
          if (frame_done) begin
            state_q     <= OUT;
            rd_cnt_q    <= '0;
            rd_bank_q   <= in_bank_q;
            out_valid_q <= 1'b1;
          end
        end
        OUT: begin
          rd_cnt_q <= rd_cnt_q + 4'd1;
          if (rd_cnt_q == 4'd15) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_up    = bank_q[rd_bank_q][{1'b0, rd_cnt_q}];
  assign out_down  = bank_q[rd_bank_q][{1'b1, rd_cnt_q}];
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q & (rd_cnt_q == 4'd15);

endmodule

// File: tb/tb_pair_reorder_in_buffer.sv
// Scoreboard bench for pair_reorder_in_buffer: a frame-level model predicts pairs and their cycle; a monitor checks them.
module tb_pair_reorder_in_buffer;
  localparam int unsigned W = 11;

  logic         clk = 1'b0;
  logic         i_rst = 1'b1;
  logic [W-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic [W-1:0] out_up, out_down;
  logic         out_valid, out_last;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [W-1:0] up;
    logic [W-1:0] down;
    logic         last;
    int unsigned  due;
  } exp_t;

  exp_t         expq[$];
  logic [W-1:0] frame[32];
  int unsigned  mcnt = 0;
  int unsigned  edges = 0;

  pair_reorder_in_buffer #(.WORD_LEN(W)) dut (
    .clk(clk), .i_rst(i_rst), .in_data(in_data), .in_valid(in_valid),
    .out_up(out_up), .out_down(out_down), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int unsigned rev5(input int unsigned n);
    int unsigned r = 0;
    for (int i = 0; i < 5; i++) r = (r << 1) | ((n >> i) & 1);
    return r;
  endfunction

  // Reference model: collect a frame, then emit x[k], x[k+16] starting one cycle after the final sample.
  always @(posedge clk) begin
    int unsigned idx;
    edges++;
    if (i_rst) begin
      mcnt = 0;
      expq.delete();
    end else if (in_valid) begin
`ifdef PAIR_REORDER_BITREV_IN_EN
      idx = rev5(mcnt);
`else
      idx = mcnt;
`endif
      frame[idx] = in_data;
      mcnt++;
      if (mcnt == 32) begin
        mcnt = 0;
        for (int k = 0; k < 16; k++) begin
          exp_t e;
          e.up = frame[k]; e.down = frame[k+16]; e.last = (k == 15); e.due = edges + k;
          expq.push_back(e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pair: got up=%0d down=%0d last=%0b at edge %0d, required no output",
                 out_up, out_down, out_last, edges);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (out_up !== e.up || out_down !== e.down || out_last !== e.last || edges != e.due) begin
          errors++;
          $display("FAIL pair: got up=%0d down=%0d last=%0b edge=%0d, required up=%0d down=%0d last=%0b edge=%0d",
                   out_up, out_down, out_last, edges, e.up, e.down, e.last, e.due);
        end
      end
    end else begin
      checks++;
      if (out_valid !== 1'b0 || out_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_flags: got valid=%b last=%b, required valid=0 last=0", out_valid, out_last);
      end
      if (expq.size() > 0 && expq[0].due <= edges) begin
        exp_t e;
        checks++;
        errors++;
        e = expq.pop_front();
        $display("FAIL missing_pair: got valid=0 at edge %0d, required up=%0d down=%0d",
                 edges, e.up, e.down);
      end
    end
  end

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    in_valid = v; in_data = d; i_rst = r;
    @(posedge clk); #1;
  endtask

  task automatic check_idle(input string name, input logic want_zero_data);
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 ||
        (want_zero_data && (out_up !== '0 || out_down !== '0))) begin
      errors++;
      $display("FAIL %s: got valid=%b last=%b up=%0d down=%0d, required valid=0 last=0%s",
               name, out_valid, out_last, out_up, out_down, want_zero_data ? " up=0 down=0" : "");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  initial begin
    drive(1'b0, '0, 1'b1);
    check_idle("reset_state", 1'b1);
    drive(1'b0, '0, 1'b1);
    idle(3);

    // Continuous frame (bit-reversed contents when that input order is enabled).
    for (int n = 0; n < 32; n++) begin
`ifdef PAIR_REORDER_BITREV_IN_EN
      drive(1'b1, W'(rev5(n)), 1'b0);
`else
      drive(1'b1, W'(n + 1), 1'b0);
`endif
    end
    idle(20);

    // Three back-to-back frames.
    for (int n = 1; n <= 96; n++) drive(1'b1, W'(n), 1'b0);
    idle(20);

    // Bursty frame.
    for (int n = 1; n <= 32; n++) begin
      drive(1'b1, W'(n), 1'b0);
      drive(1'b0, '0, 1'b0);
    end
    idle(20);

    // Reset mid-frame discards the partial frame.
    for (int n = 0; n < 20; n++) drive(1'b1, W'(200 + n), 1'b0);
    drive(1'b0, '0, 1'b1);
    for (int n = 100; n <= 131; n++) drive(1'b1, W'(n), 1'b0);
    idle(20);

    // Reset while rd_cnt=5 is on the outputs.
    for (int n = 0; n < 32; n++) drive(1'b1, W'(300 + n), 1'b0);
    idle(5);
    drive(1'b0, '0, 1'b1);
    check_idle("reset_mid_output", 1'b0);
    for (int n = 0; n < 32; n++) drive(1'b1, W'(400 + n), 1'b0);
    idle(20);

    // Randomised bursty traffic with rare resets.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 299) == 0);
    end
    idle(40);

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pairs never output, required 0", expq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
